fifo_sync_param: RTL

Parametrised single-clock FIFO for the transaction-layer datapath. It is the successor to the fixed 10-bit push/pop FIFO. Width, depth and almost-full/almost-empty thresholds are generics. It adds an occupancy count, full/empty flags, a read-valid strobe, defined simultaneous push/pop behaviour, and sticky overflow/underflow error flags with a clear input. It buffers words between a producer and a consumer stage, and both stages share one clock.

---
 rtl/fifo_sync_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with registered read data,
// an occupancy count, threshold flags and sticky overflow/underflow flags.
// A pop of an empty FIFO is never satisfied by a word pushed in the same
// cycle; that word becomes readable one cycle later.
module fifo_sync_param #(
  parameter int DATA_WIDTH       = 10,
  parameter int DEPTH            = 8,
  parameter int ALMOST_FULL_LVL  = 6,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          err_clr,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          valid,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(ALMOST_FULL_LVL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(ALMOST_EMPTY_LVL);

  // Storage array; contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full_w, empty_w;
  logic push_ok, pop_ok;
  logic push_rej, pop_rej;

  // Flags are pure decodes of the count register, so they only move on a clock edge.
  always_comb begin
    full_w       = (count_q == FULL_CNT);
    empty_w      = (count_q == '0);
    almost_full  = (count_q >= AF_CNT);
    almost_empty = (count_q <= AE_CNT);
  end

  // Accept/reject decisions; a full FIFO accepts a push only when a pop frees a slot.
  always_comb begin
    push_ok  = push && (!full_w || pop);
    pop_ok   = pop && !empty_w;
    push_rej = push && full_w && !pop;
    pop_rej  = pop && empty_w;
  end

  // Next-state for pointers, count, read data and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end

    // A new error in the same cycle as err_clr takes priority over the clear.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push_rej) begin
      overflow_d = 1'b1;
    end
    if (pop_rej) begin
      underflow_d = 1'b1;
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory write port; only accepted pushes modify storage.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Drive outputs from registers and decodes.
  always_comb begin
    data_out  = data_out_q;
    valid     = valid_q;
    count     = count_q;
    full      = full_w;
    empty     = empty_w;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule
